// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment bit order is {a,b,c,d,e,f,g} = [6:0]; every constant is active low.
package seg7_pkg;

  // Driver FSM: BLANK until the first frame arrives, then SCAN until reset.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex glyphs 0..F, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Frame handshake bundle between the status-register side (master) and the
// scan driver (slave).
// Handshake: a frame transfers on every clk edge where frame_valid and
// frame_ready are both 1; the master holds data/blank/dp stable while
// frame_valid is 1 and frame_ready is 0, and ready never depends on valid.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] frame_data;
  logic [NUM_DIGITS-1:0]   frame_blank;
  logic [NUM_DIGITS-1:0]   frame_dp;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_blank,
    output frame_dp,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_blank,
    input  frame_dp,
    output frame_ready
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  // Straight table lookup, no registering here; the top owns the output flops.
  always_comb begin
    o_seg_n = SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver. Takes a frame of NUM_DIGITS hex
// nibbles, shows one digit per slot of TICKS_PER_DIGIT clocks with the last
// GUARD_TICKS of each slot dark, and swaps in a new frame only at the frame
// wrap so the display never tears.
// Optional feature macro: SEG7_DP_EN (per-digit decimal points).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int GUARD_TICKS     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     frame_if,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  scan_done,
  output state_t                dbg_state
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DRIVE_TICKS = TICKS_PER_DIGIT - GUARD_TICKS;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  state_t                  r_state;
  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_active_data;
  logic [NUM_DIGITS-1:0]   r_active_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_valid;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [6:0]              r_seg_n;
  logic                    r_scan_done;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_dp_n;
`endif

  logic                    w_accept;
  logic                    w_last_tick;
  logic                    w_wrap;
  logic                    w_drive;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  // In BLANK a frame loads straight into the active register; in SCAN only
  // an empty pending slot can take one. Ready is held low through reset.
  assign frame_if.frame_ready = rst_n & ((r_state == ST_BLANK) | ~r_pend_valid);
  assign w_accept    = frame_if.frame_valid & frame_if.frame_ready;
  assign w_last_tick = (r_tick == LAST_TICK);
  assign w_wrap      = (r_state == ST_SCAN) & w_last_tick & (r_idx == LAST_IDX);

  assign w_nibble = r_active_data[4*r_idx +: 4];
  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);
  assign w_drive  = (r_state == ST_SCAN) & (32'(r_tick) < DRIVE_TICKS)
                  & ~r_active_blank[r_idx];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_dec)
  );

  // FSM, free-running tick/digit counters and the active/pending frame store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_BLANK;
      r_tick         <= '0;
      r_idx          <= '0;
      r_active_data  <= '0;
      r_active_blank <= '0;
      r_pend_data    <= '0;
      r_pend_blank   <= '0;
      r_pend_valid   <= 1'b0;
`ifdef SEG7_DP_EN
      r_active_dp    <= '0;
      r_pend_dp      <= '0;
`endif
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_accept) begin
            r_active_data  <= frame_if.frame_data;
            r_active_blank <= frame_if.frame_blank;
`ifdef SEG7_DP_EN
            r_active_dp    <= frame_if.frame_dp;
`endif
            r_tick         <= '0;
            r_idx          <= '0;
            r_state        <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Counters never stall; the handshake only touches the frame store.
          if (w_last_tick) begin
            r_tick <= '0;
            r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
          // Swap at the wrap only. Accept requires an empty pending slot,
          // so it can never collide with a swap in the same cycle.
          if (w_wrap && r_pend_valid) begin
            r_active_data  <= r_pend_data;
            r_active_blank <= r_pend_blank;
`ifdef SEG7_DP_EN
            r_active_dp    <= r_pend_dp;
`endif
            r_pend_valid   <= 1'b0;
          end
          if (w_accept) begin
            r_pend_data  <= frame_if.frame_data;
            r_pend_blank <= frame_if.frame_blank;
`ifdef SEG7_DP_EN
            r_pend_dp    <= frame_if.frame_dp;
`endif
            r_pend_valid <= 1'b1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  // Registered pin stage: one cycle behind the counters, all dark in guard,
  // in blanked slots, in BLANK state and during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an_n      <= '1;
      r_seg_n     <= SEG_OFF;
      r_scan_done <= 1'b0;
`ifdef SEG7_DP_EN
      r_dp_n      <= 1'b1;
`endif
    end else begin
      r_an_n      <= w_drive ? w_an_sel  : '1;
      r_seg_n     <= w_drive ? w_seg_dec : SEG_OFF;
      r_scan_done <= w_wrap;
`ifdef SEG7_DP_EN
      r_dp_n      <= w_drive ? ~r_active_dp[r_idx] : 1'b1;
`endif
    end
  end

  assign an_n      = r_an_n;
  assign seg_n     = r_seg_n;
  assign scan_done = r_scan_done;
  assign dbg_state = r_state;

`ifdef SEG7_DP_EN
  assign dp_n = r_dp_n;
`else
  // Decimal points are not built in this configuration.
  logic w_unused_dp;
  assign w_unused_dp = ^frame_if.frame_dp;
  assign dp_n = 1'b1;
`endif

endmodule
